// File: rtl/sa_pkg.sv
// Shared types and default widths for the systolic-array tile scheduler.
package sa_pkg;

    localparam int unsigned SA_R  = 4;
    localparam int unsigned SA_C  = 8;
    localparam int unsigned SA_WX = 4;
    localparam int unsigned SA_WK = 8;
    localparam int unsigned SA_AW = 16;
    localparam int unsigned SA_KW = 12;
    localparam int unsigned SA_TW = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sa_state_e;

    // One beat as it travels through the skid FIFO; packing order matches the
    // {last, x, k} payload built by the scheduler.
    typedef struct packed {
        logic                      last;
        logic [SA_R*SA_WX-1:0]     x;
        logic [SA_C*SA_WK-1:0]     k;
    } sa_beat_t;

endpackage

// File: rtl/sa_skid2.sv
// Two-entry synchronous FIFO; the head entry is presented combinationally.
module sa_skid2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];
    assign valid   = (occ != 2'd0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            occ <= occ + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/sa_tile_sched.sv
// Tile scheduler: walks mt/nt/k over the X and K operand buffers, streams each
// tile to the systolic array as one packet and waits for all output tiles.
// Optional performance counters are enabled with `define SA_SCHED_PERF_EN.
module sa_tile_sched
    import sa_pkg::*;
#(
    parameter int unsigned R  = SA_R,
    parameter int unsigned C  = SA_C,
    parameter int unsigned WX = SA_WX,
    parameter int unsigned WK = SA_WK,
    parameter int unsigned AW = SA_AW,
    parameter int unsigned KW = SA_KW,
    parameter int unsigned TW = SA_TW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [KW-1:0]   cmd_k,
    input  logic [TW-1:0]   cmd_mt,
    input  logic [TW-1:0]   cmd_nt,
    input  logic [AW-1:0]   cmd_xbase,
    input  logic [AW-1:0]   cmd_kbase,
    output logic            x_rd_en,
    output logic [AW-1:0]   x_addr,
    input  logic [R*WX-1:0] x_rdata,
    output logic            k_rd_en,
    output logic [AW-1:0]   k_addr,
    input  logic [C*WK-1:0] k_rdata,
    output logic            s_valid,
    input  logic            s_ready,
    output logic            s_last,
    output logic [R*WX-1:0] sx_data,
    output logic [C*WK-1:0] sk_data,
    input  logic            m_valid,
    input  logic            m_ready,
    input  logic            m_last,
    output logic            busy,
    output logic            done
`ifdef SA_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_starve
`endif
);

    localparam int unsigned XW  = R * WX;
    localparam int unsigned KDW = C * WK;
    localparam int unsigned BW  = 1 + XW + KDW;
    localparam int unsigned NW  = 2 * TW;

    sa_state_e       state, state_nxt;
    logic [KW-1:0]   k_max, k_cnt;
    logic [TW-1:0]   mt_max, nt_max, mt_cnt, nt_cnt;
    logic [AW-1:0]   kbase, x_row_base, k_col_base, stride;
    logic [NW-1:0]   total_tiles, tiles_out;
    logic            inflight, inflight_last;
    logic            k_end, nt_end, mt_end;
    logic            accept, pop, issue_ok;
    logic [2:0]      pend_lhs, pend_rhs;
    logic [1:0]      occ;
    logic [BW-1:0]   head;

    assign stride   = AW'(k_max) + AW'(1);
    assign k_end    = (k_cnt == k_max);
    assign nt_end   = (nt_cnt == nt_max);
    assign mt_end   = (mt_cnt == mt_max);
    assign accept   = (state == IDLE) && cmd_valid;
    assign pop      = s_valid && s_ready;
    // occ + inflight - pop < 2, rearranged to stay non-negative.
    assign pend_lhs = 3'(occ) + 3'(inflight);
    assign pend_rhs = 3'd2 + 3'(pop);
    assign issue_ok = (pend_lhs < pend_rhs);
    assign k_rd_en  = x_rd_en;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        x_rd_en   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                x_rd_en = issue_ok;
                if (issue_ok && k_end && nt_end && mt_end) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if ((occ == 2'd0) && !inflight && (tiles_out == total_tiles))
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch and address walk; running bases replace mt*(K+1) and nt*(K+1).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            k_max       <= '0;
            mt_max      <= '0;
            nt_max      <= '0;
            kbase       <= '0;
            total_tiles <= '0;
            k_cnt       <= '0;
            mt_cnt      <= '0;
            nt_cnt      <= '0;
            x_row_base  <= '0;
            k_col_base  <= '0;
            x_addr      <= '0;
            k_addr      <= '0;
        end else if (accept) begin
            k_max       <= cmd_k;
            mt_max      <= cmd_mt;
            nt_max      <= cmd_nt;
            kbase       <= cmd_kbase;
            total_tiles <= (NW'(cmd_mt) + NW'(1)) * (NW'(cmd_nt) + NW'(1));
            k_cnt       <= '0;
            mt_cnt      <= '0;
            nt_cnt      <= '0;
            x_row_base  <= cmd_xbase;
            k_col_base  <= cmd_kbase;
            x_addr      <= cmd_xbase;
            k_addr      <= cmd_kbase;
        end else if (x_rd_en) begin
            if (!k_end) begin
                k_cnt  <= k_cnt + KW'(1);
                x_addr <= x_addr + AW'(1);
                k_addr <= k_addr + AW'(1);
            end else begin
                k_cnt <= '0;
                if (!nt_end) begin
                    nt_cnt     <= nt_cnt + TW'(1);
                    k_col_base <= k_col_base + stride;
                    k_addr     <= k_col_base + stride;
                    x_addr     <= x_row_base;
                end else begin
                    nt_cnt     <= '0;
                    mt_cnt     <= mt_cnt + TW'(1);
                    x_row_base <= x_row_base + stride;
                    x_addr     <= x_row_base + stride;
                    k_col_base <= kbase;
                    k_addr     <= kbase;
                end
            end
        end
    end

    // Track the read in flight and its last-beat tag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= x_rd_en;
            inflight_last <= x_rd_en && k_end;
        end
    end

    // Count output tiles leaving the array.
    always_ff @(posedge clk) begin
        if (!rstn)                                        tiles_out <= '0;
        else if (accept)                                  tiles_out <= '0;
        else if (busy && m_valid && m_ready && m_last)    tiles_out <= tiles_out + NW'(1);
    end

    sa_skid2 #(.W(BW)) u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight),
        .din   ({inflight_last, x_rdata, k_rdata}),
        .pop   (pop),
        .dout  (head),
        .valid (s_valid),
        .occ   (occ)
    );

    assign s_last  = head[BW-1];
    assign sx_data = head[BW-2 -: XW];
    assign sk_data = head[KDW-1:0];

`ifdef SA_SCHED_PERF_EN
    // Saturating performance counters, cleared on command accept.
    always_ff @(posedge clk) begin
        if (!rstn || accept) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
            perf_starve <= '0;
        end else begin
            if (busy && (perf_cycles != '1))                 perf_cycles <= perf_cycles + 32'd1;
            if (s_valid && !s_ready && (perf_stall != '1))   perf_stall  <= perf_stall + 32'd1;
            if ((state == RUN) && !s_valid && (perf_starve != '1))
                perf_starve <= perf_starve + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_tile_sched.sv
// Self-checking bench for sa_tile_sched with buffer and array models.
module tb_sa_tile_sched;
    import sa_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_k = '0;
    logic [7:0]  cmd_mt = '0, cmd_nt = '0;
    logic [15:0] cmd_xbase = '0, cmd_kbase = '0;
    logic        x_rd_en, k_rd_en;
    logic [15:0] x_addr, k_addr;
    logic [15:0] x_rdata = '0;
    logic [63:0] k_rdata = '0;
    logic        s_valid, s_last;
    logic        s_ready = 1'b0;
    logic [15:0] sx_data;
    logic [63:0] sk_data;
    logic        m_valid = 1'b0, m_ready = 1'b0, m_last = 1'b0;
    logic        busy, done;
`ifdef SA_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stall, perf_starve;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_pct = 100;

    sa_beat_t    obs_q[$];
    int          obs_cyc_q[$];
    logic [15:0] rdx_q[$], rdk_q[$];
    int          rd_cyc_q[$];
    int          acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;

    sa_beat_t    exp_b[$];
    logic [15:0] exp_x[$], exp_k[$];

    sa_tile_sched dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .cmd_mt(cmd_mt), .cmd_nt(cmd_nt), .cmd_xbase(cmd_xbase), .cmd_kbase(cmd_kbase),
        .x_rd_en(x_rd_en), .x_addr(x_addr), .x_rdata(x_rdata),
        .k_rd_en(k_rd_en), .k_addr(k_addr), .k_rdata(k_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .sx_data(sx_data), .sk_data(sk_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
`ifdef SA_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall), .perf_starve(perf_starve)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] xmem(input logic [15:0] a);
        return a ^ 16'hA5C3 ^ {a[7:0], a[15:8]};
    endfunction
    function automatic logic [63:0] kmem(input logic [15:0] a);
        return {a, ~a, a ^ 16'h3C3C, a + 16'h1111};
    endfunction

    // Synchronous-read operand buffers, one cycle latency.
    always @(posedge clk) begin
        if (x_rd_en) x_rdata <= xmem(x_addr);
        if (k_rd_en) k_rdata <= kmem(k_addr);
    end

    // Random array backpressure.
    always @(posedge clk) begin
        #1;
        s_ready = ($urandom_range(0, 99) < ready_pct);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor, sampled on the falling edge.
    logic     prev_stall = 1'b0;
    sa_beat_t prev_beat;
    always @(negedge clk) begin : mon
        sa_beat_t b;
        b.last = s_last; b.x = sx_data; b.k = sk_data;
        if (rstn) begin
            chk("rd_en_match", 64'(k_rd_en), 64'(x_rd_en));
            chk("fifo_occ_le2", 64'(dut.u_skid.occ <= 2'd2), 64'd1);
            if (prev_stall) begin
                chk("stall_valid", 64'(s_valid), 64'd1);
                chk("stall_last", 64'(s_last), 64'(prev_beat.last));
                chk("stall_x", 64'(sx_data), 64'(prev_beat.x));
                chk("stall_k", sk_data, prev_beat.k);
            end
            if (cmd_valid && cmd_ready) begin acc_cnt++; acc_cyc = cyc; end
            if (x_rd_en) begin
                rdx_q.push_back(x_addr); rdk_q.push_back(k_addr); rd_cyc_q.push_back(cyc);
            end
            if (s_valid && s_ready) begin obs_q.push_back(b); obs_cyc_q.push_back(cyc); end
            if (done) begin
                done_cnt++; done_cyc = cyc;
                chk("done_not_busy", 64'(busy), 64'd0);
            end
            prev_stall = s_valid && !s_ready;
            prev_beat  = b;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference: nested mt/nt/k loops with plain multiplication.
    task automatic model(input int kk, input int mt, input int nt,
                         input logic [15:0] xb, input logic [15:0] kb);
        sa_beat_t e;
        logic [15:0] xa, ka;
        exp_b.delete(); exp_x.delete(); exp_k.delete();
        for (int m = 0; m <= mt; m++)
            for (int n = 0; n <= nt; n++)
                for (int k = 0; k <= kk; k++) begin
                    xa = 16'(int'(xb) + m * (kk + 1) + k);
                    ka = 16'(int'(kb) + n * (kk + 1) + k);
                    exp_x.push_back(xa); exp_k.push_back(ka);
                    e.last = (k == kk); e.x = xmem(xa); e.k = kmem(ka);
                    exp_b.push_back(e);
                end
    endtask

    task automatic drive_cmd(input int kk, input int mt, input int nt,
                             input logic [15:0] xb, input logic [15:0] kb);
        cmd_k = 12'(kk); cmd_mt = 8'(mt); cmd_nt = 8'(nt);
        cmd_xbase = xb; cmd_kbase = kb;
    endtask

    task automatic send_cmd(input string tag, input int kk, input int mt, input int nt,
                            input logic [15:0] xb, input logic [15:0] kb);
        int a0, c;
        a0 = acc_cnt; c = 0;
        @(posedge clk); #1;
        drive_cmd(kk, mt, nt, xb, kb);
        cmd_valid = 1'b1;
        while (acc_cnt == a0 && c < 50) begin @(negedge clk); #1; c++; end
        chk({tag, "_accept"}, 64'(acc_cnt - a0), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int base, input int n, input int budget);
        int c = 0;
        while (obs_q.size() < base + n && c < budget) begin @(negedge clk); #1; c++; end
        chk({tag, "_beats_in_time"}, 64'(obs_q.size() >= base + n), 64'd1);
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int bb, input int bx);
        chk({tag, "_nbeats"}, 64'(obs_q.size() - bb), 64'(exp_b.size()));
        chk({tag, "_nreads"}, 64'(rdx_q.size() - bx), 64'(exp_x.size()));
        for (int i = 0; i < exp_b.size(); i++)
            if (bb + i < obs_q.size()) begin
                chk({tag, "_last"}, 64'(obs_q[bb+i].last), 64'(exp_b[i].last));
                chk({tag, "_x"}, 64'(obs_q[bb+i].x), 64'(exp_b[i].x));
                chk({tag, "_k"}, obs_q[bb+i].k, exp_b[i].k);
            end
        for (int i = 0; i < exp_x.size(); i++)
            if (bx + i < rdx_q.size()) begin
                chk({tag, "_xaddr"}, 64'(rdx_q[bx+i]), 64'(exp_x[i]));
                chk({tag, "_kaddr"}, 64'(rdk_q[bx+i]), 64'(exp_k[i]));
            end
    endtask

    task automatic send_mlast(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            m_valid = 1'b1; m_ready = 1'b1; m_last = 1'b1;
            @(posedge clk); #1;
            m_valid = 1'b0; m_ready = 1'b0; m_last = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int d0, c;
        d0 = done_cnt; c = 0;
        while (done_cnt == d0 && c < 40) begin @(negedge clk); #1; c++; end
        chk({tag, "_done_pulse"}, 64'(done_cnt - d0), 64'd1);
        @(negedge clk); #1;
        chk({tag, "_done_single"}, 64'(done), 64'd0);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_x_rd_en"}, 64'(x_rd_en), 64'd0);
        chk({tag, "_k_rd_en"}, 64'(k_rd_en), 64'd0);
        chk({tag, "_x_addr"}, 64'(x_addr), 64'd0);
        chk({tag, "_k_addr"}, 64'(k_addr), 64'd0);
        chk({tag, "_s_valid"}, 64'(s_valid), 64'd0);
        chk({tag, "_s_last"}, 64'(s_last), 64'd0);
        chk({tag, "_sx_data"}, 64'(sx_data), 64'd0);
        chk({tag, "_sk_data"}, sk_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bb, bx, d0, a1, c, kk, mt, nt;
        logic [15:0] xb, kb;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rstn = 1'b1;

        // Single tile, latency and completion.
        bb = obs_q.size(); bx = rdx_q.size();
        model(2, 0, 0, 16'h0010, 16'h0040);
        send_cmd("t1", 2, 0, 0, 16'h0010, 16'h0040);
        wait_beats("t1", bb, 3, 50);
        check_stream("t1", bb, bx);
        if (rd_cyc_q.size() > bx) chk("t1_rd_latency", 64'(rd_cyc_q[bx] - acc_cyc), 64'd1);
        if (obs_cyc_q.size() > bb) chk("t1_sv_latency", 64'(obs_cyc_q[bb] - acc_cyc), 64'd3);
        chk("t1_busy_wait", 64'(busy), 64'd1);
        send_mlast(1);
        wait_done("t1");

        // Multi-tile; done only after the sixth output tile.
        bb = obs_q.size(); bx = rdx_q.size();
        model(1, 1, 2, 16'h0000, 16'h0000);
        send_cmd("t2", 1, 1, 2, 16'h0000, 16'h0000);
        wait_beats("t2", bb, 12, 80);
        check_stream("t2", bb, bx);
        d0 = done_cnt;
        @(posedge clk); #1;
        m_valid = 1'b1; m_ready = 1'b0; m_last = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b1; m_ready = 1'b1; m_last = 1'b0;
        @(posedge clk); #1;
        m_valid = 1'b0; m_ready = 1'b0; m_last = 1'b0;
        send_mlast(5);
        repeat (6) @(negedge clk);
        #1;
        chk("t2_no_early_done", 64'(done_cnt - d0), 64'd0);
        chk("t2_still_busy", 64'(busy), 64'd1);
        send_mlast(1);
        wait_done("t2");

        // Backpressure with random commands; the first forces address wrap.
        ready_pct = 30;
        for (int t = 0; t < 3; t++) begin
            kk = $urandom_range(0, 5); mt = $urandom_range(0, 2); nt = $urandom_range(0, 2);
            xb = (t == 0) ? 16'hFFFC : 16'($urandom);
            kb = (t == 0) ? 16'hFFFE : 16'($urandom);
            bb = obs_q.size(); bx = rdx_q.size();
            model(kk, mt, nt, xb, kb);
            send_cmd("t3", kk, mt, nt, xb, kb);
            wait_beats("t3", bb, exp_b.size(), exp_b.size() * 40 + 100);
            check_stream("t3", bb, bx);
            send_mlast((mt + 1) * (nt + 1));
            wait_done("t3");
        end
        ready_pct = 100;

        // Reset in the middle of RUN, then a clean command.
        bb = obs_q.size(); bx = rdx_q.size();
        model(7, 1, 1, 16'h0100, 16'h0200);
        send_cmd("t4", 7, 1, 1, 16'h0100, 16'h0200);
        c = 0;
        while (obs_q.size() < bb + 5 && c < 60) begin @(negedge clk); #1; c++; end
        chk("t4_five_beats", 64'(obs_q.size() >= bb + 5), 64'd1);
        for (int i = 0; i < 5; i++)
            if (bb + i < obs_q.size()) chk("t4_pre_x", 64'(obs_q[bb+i].x), 64'(exp_b[i].x));
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk_reset("t4rst");
        rstn = 1'b1;
        bb = obs_q.size(); bx = rdx_q.size();
        repeat (5) @(negedge clk);
        #1;
        chk("t4_no_stale", 64'(obs_q.size() - bb), 64'd0);
        model(2, 1, 0, 16'h0300, 16'h0500);
        send_cmd("t4b", 2, 1, 0, 16'h0300, 16'h0500);
        wait_beats("t4b", bb, 6, 60);
        check_stream("t4b", bb, bx);
        send_mlast(2);
        wait_done("t4b");

        // cmd_k=0 single-beat packets; a held command waits until after done.
        bb = obs_q.size(); bx = rdx_q.size();
        model(0, 0, 3, 16'h0020, 16'h0060);
        @(posedge clk); #1;
        drive_cmd(0, 0, 3, 16'h0020, 16'h0060);
        cmd_valid = 1'b1;
        a1 = acc_cnt; c = 0;
        while (acc_cnt == a1 && c < 20) begin @(negedge clk); #1; c++; end
        chk("t5_accept", 64'(acc_cnt - a1), 64'd1);
        a1 = acc_cnt;
        @(posedge clk); #1;
        drive_cmd(0, 0, 0, 16'h0070, 16'h0080);
        wait_beats("t5", bb, 4, 60);
        check_stream("t5", bb, bx);
        chk("t5_held_not_taken", 64'(acc_cnt - a1), 64'd0);
        send_mlast(4);
        bb = obs_q.size(); bx = rdx_q.size();
        wait_done("t5");
        c = 0;
        while (acc_cnt == a1 && c < 20) begin @(negedge clk); #1; c++; end
        chk("t5_held_taken", 64'(acc_cnt - a1), 64'd1);
        chk("t5_after_done", 64'(acc_cyc - done_cyc), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model(0, 0, 0, 16'h0070, 16'h0080);
        wait_beats("t5b", bb, 1, 40);
        check_stream("t5b", bb, bx);
        send_mlast(1);
        wait_done("t5b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_tile_sched.md
Name: sa_tile_sched

Overview:
- Tile scheduler that sequences the AXI-Stream systolic array over a full matrix product.
- Accepts one command describing M-tiles × N-tiles × K-depth.
- Generates read addresses into the X and K operand buffers, which are synchronous-read with 1-cycle latency.
- Streams each tile to the array as one packet of K beats, with s_last on the final beat.
- Counts completed output tiles (m_last handshakes) and pulses done when everything has drained.

Parameters:
- R, 4, array rows; X beat carries R words.
- C, 8, array columns; K beat carries C words.
- WX, 4, X element width.
- WK, 8, K element width.
- AW, 16, operand buffer address width.
- KW, 12, width of the K-depth field.
- TW, 8, width of the tile-count fields.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_k  in  KW  K-depth minus 1 (beats per tile minus 1)
- cmd_mt  in  TW  row tiles minus 1
- cmd_nt  in  TW  column tiles minus 1
- cmd_xbase  in  AW  X buffer base address
- cmd_kbase  in  AW  K buffer base address
- x_rd_en  out  1  X buffer read strobe
- x_addr  out  AW  X read address
- x_rdata  in  R*WX  X read data, valid 1 cycle after x_rd_en
- k_rd_en  out  1  K buffer read strobe, always equal to x_rd_en
- k_addr  out  AW  K read address
- k_rdata  in  C*WK  K read data, valid 1 cycle after k_rd_en
- s_valid  out  1  beat valid to array
- s_ready  in  1  array ready
- s_last  out  1  last beat of tile
- sx_data  out  R*WX  X beat to array
- sk_data  out  C*WK  K beat to array
- m_valid  in  1  array output valid (monitored only)
- m_ready  in  1  downstream ready (monitored only)
- m_last  in  1  array output last (monitored only)
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse when all tiles have drained

Behaviour:
- Reset values:
  - state IDLE; cmd_ready=1.
  - x_rd_en=k_rd_en=0; x_addr=k_addr=0.
  - s_valid=0; s_last=0; sx_data=sk_data=0.
  - busy=0; done=0.
  - Skid FIFO empty; in-flight flag 0; all counters 0.
- Reset mid-operation: abandon everything immediately. Returned read data in the following cycle is discarded.
- FSM states:
  - IDLE: on cmd_valid, latch all cmd fields, set busy, go to RUN.
  - RUN: issue reads; when the last beat of the last tile has been issued, go to DRAIN.
  - DRAIN: wait until skid FIFO is empty, no read is in flight, and tiles_out == total_tiles.
  - DONE: assert done for 1 cycle, clear busy, return to IDLE.
- Address loop order: mt outer, nt middle, k innermost.
  - x_addr = xbase + mt*(K+1) + k.
  - k_addr = kbase + nt*(K+1) + k.
  - Implemented with running base registers and adders only; no multipliers.
  - Addresses wrap modulo 2^AW.
- Read issue rule: issue in RUN when (fifo_occ + inflight − pop) < 2, where pop = s_valid && s_ready. This sustains 1 beat/cycle while s_ready stays high.
- Data return: returned data plus the tag last = (k == K) is pushed into the 2-entry skid FIFO.
  - FIFO head drives s_valid, s_last, sx_data and sk_data.
  - Head is held stable while s_valid && !s_ready (AXIS rule).
- Latency: command accepted at cycle T → first rd_en at T+1 → data at T+2 → s_valid at T+3.
- Output tile counting: tiles_out increments on m_valid && m_ready && m_last.
  - total_tiles = (mt+1)*(nt+1), computed once in IDLE→RUN, width 2*TW.
- cmd_k = 0 is legal: every beat has s_last=1.
- A command presented while busy is not accepted (cmd_ready=0).
- FIFO overflow is impossible by construction; the bench asserts this.

Optional Feature:
- Macro SA_SCHED_PERF_EN.
- When defined, adds three outputs, each a 32-bit saturating counter cleared on command accept:
  - perf_cycles: counts busy cycles.
  - perf_stall: counts cycles with s_valid && !s_ready.
  - perf_starve: counts RUN cycles with s_valid=0.
- When undefined, the ports and logic are absent.

Decomposition:
- Package sa_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default widths;
  - a packed beat struct {last, x, k}.
- One sub-module, sa_skid2: a 2-entry synchronous FIFO with push, pop, occupancy and a parameterized payload.

Test Plan:
- Single tile: K=3 (cmd_k=2), mt=nt=0, xbase=0x10, kbase=0x40, s_ready=1.
  - Reads x 0x10–0x12 and k 0x40–0x42.
  - 3 beats; s_last on the 3rd; first s_valid at T+3.
  - After one m_last handshake: done pulse, busy drops.
- Multi-tile: cmd_k=1, mt=1, nt=2.
  - x_addr sequence 0,1,0,1,0,1,2,3,2,3,2,3.
  - k_addr sequence 0,1,2,3,4,5,0,1,2,3,4,5.
  - 6 packets; done only after 6 m_last handshakes.
- Backpressure: s_ready random at 30%.
  - Beats stay ordered and stable during stalls.
  - FIFO occupancy never exceeds 2.
  - Total beat count is exact.
- Reset mid-RUN after 5 beats: all outputs return to reset values on the next cycle.
  - A new command then runs cleanly from its own bases.
- cmd_k=0 with mt=0, nt=3: 4 single-beat packets, each with s_last=1.
  - A cmd_valid held high during busy is not accepted until after done.
